// File: rtl/mem_copy_dma_if.sv
// Control and memory-initiator signals of the block copy / fill engine.
// master is the engine side; slave is the host plus RAM side.
interface mem_copy_dma_if;
  logic        Start;
  logic [15:0] SrcAddr;
  logic [15:0] DstAddr;
  logic [15:0] Length;
  logic        Fill;
  logic [7:0]  FillByte;
  logic        Busy;
  logic        Done;
  logic        MemWE;
  logic [15:0] MemAddress;
  logic [7:0]  MemDataOut;
  logic [7:0]  MemDataIn;

  modport master (
    input  Start, SrcAddr, DstAddr, Length, Fill, FillByte, MemDataIn,
    output Busy, Done, MemWE, MemAddress, MemDataOut
  );

  modport slave (
    output Start, SrcAddr, DstAddr, Length, Fill, FillByte, MemDataIn,
    input  Busy, Done, MemWE, MemAddress, MemDataOut
  );
endinterface

// File: rtl/mem_copy_dma.sv
// Byte-block copy engine mastering a synchronous RAM, two clocks per byte.
// Define MEM_COPY_FILL_EN to add the one-clock-per-byte constant fill mode.
module mem_copy_dma (
  input  logic            CLK,
  input  logic            RST,
  mem_copy_dma_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_count;
  logic [15:0] r_memAddress;
  logic        r_memWE;
  logic        r_done;
  logic [15:0] w_nextSrc;
  logic [15:0] w_nextDst;
  logic [15:0] w_nextCount;
  logic [15:0] w_nextMemAddress;
  logic        w_nextMemWE;
  logic        w_nextDone;
  logic        w_capture;
  logic        w_startFill;
  logic        w_fillMode;

`ifdef MEM_COPY_FILL_EN
  logic        r_fill;
  logic [7:0]  r_fillByte;

  assign w_startFill = bus.Fill;
  assign w_fillMode  = r_fill;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fill     <= 1'b0;
      r_fillByte <= 8'h00;
    end else if (w_capture) begin
      r_fill     <= bus.Fill;
      r_fillByte <= bus.FillByte;
    end
  end

  assign bus.MemDataOut = (r_fill && (r_state == WRITE)) ? r_fillByte : bus.MemDataIn;
`else
  logic w_unused;

  assign w_startFill    = 1'b0;
  assign w_fillMode     = 1'b0;
  assign w_unused       = ^{bus.Fill, bus.FillByte, w_capture};
  assign bus.MemDataOut = bus.MemDataIn;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_src        <= 16'h0000;
      r_dst        <= 16'h0000;
      r_count      <= 16'h0000;
      r_memAddress <= 16'h0000;
      r_memWE      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_src        <= w_nextSrc;
      r_dst        <= w_nextDst;
      r_count      <= w_nextCount;
      r_memAddress <= w_nextMemAddress;
      r_memWE      <= w_nextMemWE;
      r_done       <= w_nextDone;
    end
  end

  // Bus address and write enable are computed for the state being entered,
  // so they are valid for the whole cycle that follows the edge.
  always_comb begin
    w_nextState      = r_state;
    w_nextSrc        = r_src;
    w_nextDst        = r_dst;
    w_nextCount      = r_count;
    w_nextMemAddress = 16'h0000;
    w_nextMemWE      = 1'b0;
    w_nextDone       = 1'b0;
    w_capture        = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          if (bus.Length != 16'h0000) begin
            w_capture   = 1'b1;
            w_nextSrc   = bus.SrcAddr;
            w_nextDst   = bus.DstAddr;
            w_nextCount = bus.Length;
            if (w_startFill) begin
              w_nextState      = WRITE;
              w_nextMemAddress = bus.DstAddr;
              w_nextMemWE      = 1'b1;
            end else begin
              w_nextState      = READ;
              w_nextMemAddress = bus.SrcAddr;
            end
          end else begin
            w_nextDone = 1'b1;
          end
        end
      end

      READ: begin
        w_nextState      = WRITE;
        w_nextMemAddress = r_dst;
        w_nextMemWE      = 1'b1;
      end

      WRITE: begin
        w_nextSrc   = r_src + 16'd1;
        w_nextDst   = r_dst + 16'd1;
        w_nextCount = r_count - 16'd1;
        if (r_count == 16'd1) begin
          w_nextState = IDLE;
          w_nextDone  = 1'b1;
        end else if (w_fillMode) begin
          w_nextState      = WRITE;
          w_nextMemAddress = r_dst + 16'd1;
          w_nextMemWE      = 1'b1;
        end else begin
          w_nextState      = READ;
          w_nextMemAddress = r_src + 16'd1;
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign bus.Busy       = (r_state != IDLE);
  assign bus.Done       = r_done;
  assign bus.MemWE      = r_memWE;
  assign bus.MemAddress = r_memAddress;

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Bus-master copy engine that drives the initiator side of the team's single-port synchronous byte RAM (write enable, 16-bit address, write data, registered read data). On a start pulse it moves a block of bytes from a source address to a destination address, two clocks per byte. It can also fill a region with a constant byte. It sits beside the 6502 core as a second memory master; arbitration against the CPU is outside this block.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  begin-transfer request; sampled only in IDLE.
- SrcAddr  in  16  source start address; captured on the accepted Start.
- DstAddr  in  16  destination start address; captured on the accepted Start.
- Length  in  16  byte count, 0..65535; captured on the accepted Start.
- Fill  in  1  fill-mode select; captured on the accepted Start. Used only with MEM_COPY_FILL_EN.
- FillByte  in  8  fill constant; captured on the accepted Start. Used only with MEM_COPY_FILL_EN.
- Busy  out  1  high while in READ or WRITE.
- Done  out  1  one-cycle pulse when a transfer completes.
- MemWE  out  1  memory write enable (registered).
- MemAddress  out  16  memory address (registered).
- MemDataOut  out  8  write data to the memory DataIn (combinational).
- MemDataIn  in  8  memory DataOut. Valid in the cycle after the read address was presented.

## Operation
- The FSM has three states: IDLE, READ, WRITE.
- Registers: src ptr, dst ptr, remaining count (all 16-bit), latched Fill, latched FillByte.
- IDLE:
  - Start with Length≠0: capture inputs and go to READ. In fill mode (MEM_COPY_FILL_EN only), go directly to WRITE.
  - Start with Length=0: stay in IDLE, pulse Done on the next cycle, make no memory access.
- READ: MemAddress=src, MemWE=0. Next state is WRITE.
- WRITE: MemAddress=dst, MemWE=1.
  - MemDataOut = MemDataIn in copy mode, or latched FillByte in fill mode.
  - On the WRITE edge: src+1, dst+1, remaining−1.
  - If remaining was 1: go to IDLE and set Done. Otherwise go to READ (copy) or stay in WRITE (fill).
- Pointer arithmetic is modulo 2^16: 0xFFFF+1 wraps to 0x0000 with no flag.
- Overlap is copied forward with no overlap detection. When dst = src+1, the first byte repeats through the whole destination range.
- Start while Busy is ignored. Inputs may change freely after the accepted Start.
- In IDLE: MemWE=0 and MemAddress=0x0000. MemDataOut follows MemDataIn.

## Timing
- Reset values: Busy=0, Done=0, MemWE=0, MemAddress=0x0000, state=IDLE, all pointers and the count are 0.
- Reset asserted mid-transfer clears MemWE immediately (asynchronously), so no write occurs at the next edge. The transfer is abandoned and Done is not pulsed.
- Start is sampled at edge E0. Busy, MemAddress and MemWE take effect from E0.
- The memory latches the read address at edge E0+1. MemDataIn is valid during the WRITE cycle, and the write commits at edge E0+2.
- Copy of N bytes: Busy is high for 2N cycles. Done is high for the single cycle after the last write edge, and Busy is 0 in that cycle.
- Fill of N bytes: Busy is high for N cycles.
- Start is accepted in the same cycle Done is high. Back-to-back transfers have zero idle gap.
- Memory read-during-write returns old data. The engine never reads and writes in the same cycle, so this never matters.

## Configuration
- MEM_COPY_FILL_EN defined:
  - Fill=1 at Start selects fill mode: WRITE-only, 1 cycle/byte, data = FillByte.
- MEM_COPY_FILL_EN undefined:
  - Fill and FillByte are present but ignored.
  - Every transfer is a copy, and no fill logic is synthesized.

## Test plan
- Preload 0x0100..0x0102 = AA,BB,CC. Start src=0x0100, dst=0x0200, len=3.
  - Busy high 6 cycles, then Done one cycle.
  - 0x0200..0x0202 = AA,BB,CC. MemWE high only in the 3 WRITE cycles.
- Length=0, src=0x0010, dst=0x0020:
  - Done one cycle after Start, Busy never high, MemWE never high.
- Wrap: preload 0xFFFF=11, 0x0000=22. Copy src=0xFFFF → dst=0x0300, len=2.
  - 0x0300=11, 0x0301=22. Address sequence FFFF,0300,0000,0301.
- Assert RST during the second WRITE of a 4-byte copy.
  - MemWE drops that cycle and only byte 0 is written.
  - Busy=0 and Done=0 after reset. A subsequent Start works normally.
- Start pulsed while Busy: ignored, and the original transfer completes unchanged. Start held high during the Done cycle launches the next transfer with no gap.
- With MEM_COPY_FILL_EN: Fill=1, FillByte=5A, dst=0x0040, len=4.
  - 0x0040..0x0043 = 5A. Busy high 4 cycles.
  - Without the macro, the same stimulus performs a copy instead.
